point_add_seq: RTL

POINT_ADD_SEQ -- requirements
Module: point_add_seq

---
 rtl/point_add_seq.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/point_add_seq.sv
// Twisted-Edwards extended-coordinate point add/double over GF(Q), built around
// one shared bit-serial modular multiplier and a single-cycle modular adder.
module point_add_seq #(
    parameter int          W  = 256,
    parameter logic [W-1:0] Q  = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed,
    parameter logic [W-1:0] D2 = 256'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] z1,
    input  logic [W-1:0] t1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] y2,
    input  logic [W-1:0] z2,
    input  logic [W-1:0] t2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x3,
    output logic [W-1:0] y3,
    output logic [W-1:0] z3,
    output logic [W-1:0] t3,
    output logic [2:0]   dbg_state
);
    // Handshake: start is taken on any edge where busy=0 (IDLE or the done cycle);
    // done is high for the single FIN cycle, when x3..t3 already hold the result.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_MUL1 = 3'd2;
    localparam logic [2:0] S_MID  = 3'd3;
    localparam logic [2:0] S_MUL2 = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam int          CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    function automatic logic [W-1:0] mod_red(input logic [W-1:0] v);
        return (v >= Q) ? v - Q : v;
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + {1'b0, Q};
        return d[W-1:0];
    endfunction

    // One Horner step: acc <- 2*acc + bit*b (mod Q), both partial sums kept below Q.
    function automatic logic [W-1:0] mul_step(input logic [W-1:0] acc, input logic bit_in,
                                              input logic [W-1:0] b);
        logic [W:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, Q}) t = t - {1'b0, Q};
        t = t + {1'b0, b & {W{bit_in}}};
        if (t >= {1'b0, Q}) t = t - {1'b0, Q};
        return t[W-1:0];
    endfunction

    logic [2:0]    state_q, state_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  cx1_q, cy1_q, cz1_q, ct1_q, cx2_q, cy2_q, cz2_q, ct2_q;
    logic [W-1:0]  cx1_d, cy1_d, cz1_d, ct1_d, cx2_d, cy2_d, cz2_d, ct2_d;
    logic [W-1:0]  r_q [4];
    logic [W-1:0]  r_d [4];
    logic [W-1:0]  p_q [5];
    logic [W-1:0]  p_d [5];
    logic [W-1:0]  e_q, f_q, g_q, h_q, e_d, f_d, g_d, h_d;
    logic [W-1:0]  ma_q, mb_q, acc_q, ma_d, mb_d, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [W-1:0]  x3_q, y3_q, z3_q, t3_q, x3_d, y3_d, z3_d, t3_d;
    logic [W-1:0]  op_a, op_b, prod, mid_c, mid_h;
    logic [2:0]    last_idx;

    // Operand schedule for the shared multiplier; destination slot equals idx.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state_q == S_MUL1 && !mode_q) begin
            case (idx_q)
                3'd0:    begin op_a = r_q[0]; op_b = r_q[1]; end
                3'd1:    begin op_a = r_q[2]; op_b = r_q[3]; end
                3'd2:    begin op_a = ct1_q;  op_b = D2;     end
                3'd3:    begin op_a = p_q[2]; op_b = ct2_q;  end
                default: begin op_a = cz1_q;  op_b = cz2_q;  end
            endcase
        end else if (state_q == S_MUL1) begin
            case (idx_q)
                3'd0:    begin op_a = cx1_q;  op_b = cx1_q;  end
                3'd1:    begin op_a = cy1_q;  op_b = cy1_q;  end
                3'd2:    begin op_a = cz1_q;  op_b = cz1_q;  end
                default: begin op_a = r_q[0]; op_b = r_q[0]; end
            endcase
        end else begin
            case (idx_q)
                3'd0:    begin op_a = e_q; op_b = f_q; end
                3'd1:    begin op_a = g_q; op_b = h_q; end
                3'd2:    begin op_a = e_q; op_b = h_q; end
                default: begin op_a = f_q; op_b = g_q; end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cx1_d = cx1_q; cy1_d = cy1_q; cz1_d = cz1_q; ct1_d = ct1_q;
        cx2_d = cx2_q; cy2_d = cy2_q; cz2_d = cz2_q; ct2_d = ct2_q;
        r_d = r_q;
        p_d = p_q;
        e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
        ma_d = ma_q; mb_d = mb_q; acc_d = acc_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        x3_d = x3_q; y3_d = y3_q; z3_d = z3_q; t3_d = t3_q;
        mid_c = '0;
        mid_h = '0;
        prod = mul_step(acc_q, ma_q[W-1], mb_q);
        last_idx = (state_q == S_MUL1 && !mode_q) ? 3'd4 : 3'd3;

        case (state_q)
            S_IDLE, S_FIN: begin
                if (state_q == S_FIN) state_d = S_IDLE;
                if (start) begin
                    mode_d = mode;
                    cx1_d = mod_red(x1); cy1_d = mod_red(y1);
                    cz1_d = mod_red(z1); ct1_d = mod_red(t1);
                    cx2_d = mod_red(x2); cy2_d = mod_red(y2);
                    cz2_d = mod_red(z2); ct2_d = mod_red(t2);
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (mode_q) begin
                    r_d[0] = mod_add(cx1_q, cy1_q);
                end else begin
                    r_d[0] = mod_sub(cy1_q, cx1_q);
                    r_d[1] = mod_sub(cy2_q, cx2_q);
                    r_d[2] = mod_add(cy1_q, cx1_q);
                    r_d[3] = mod_add(cy2_q, cx2_q);
                end
                cnt_d = '0;
                idx_d = '0;
                state_d = S_MUL1;
            end
            S_MUL1, S_MUL2: begin
                if (cnt_q == '0) begin
                    ma_d  = op_a;
                    mb_d  = op_b;
                    acc_d = '0;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    acc_d = prod;
                    ma_d  = ma_q << 1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 3'd1;
                        p_d[idx_q] = prod;
                        if (idx_q == last_idx) begin
                            idx_d = '0;
                            if (state_q == S_MUL1) begin
                                state_d = S_MID;
                            end else begin
                                // Last product goes straight out so FIN already shows the result.
                                x3_d = p_q[0];
                                y3_d = p_q[1];
                                t3_d = p_q[2];
                                z3_d = prod;
                                state_d = S_FIN;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_MID: begin
                if (mode_q) begin
                    mid_c = mod_add(p_q[2], p_q[2]);
                    mid_h = mod_add(p_q[0], p_q[1]);
                    h_d = mid_h;
                    e_d = mod_sub(mid_h, p_q[3]);
                    g_d = mod_sub(p_q[0], p_q[1]);
                    f_d = mod_add(mid_c, mod_sub(p_q[0], p_q[1]));
                end else begin
                    mid_c = mod_add(p_q[4], p_q[4]);
                    e_d = mod_sub(p_q[1], p_q[0]);
                    f_d = mod_sub(mid_c, p_q[3]);
                    g_d = mod_add(mid_c, p_q[3]);
                    h_d = mod_add(p_q[1], p_q[0]);
                end
                cnt_d = '0;
                idx_d = '0;
                state_d = S_MUL2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            cx1_q <= '0; cy1_q <= '0; cz1_q <= '0; ct1_q <= '0;
            cx2_q <= '0; cy2_q <= '0; cz2_q <= '0; ct2_q <= '0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
            for (int i = 0; i < 5; i++) p_q[i] <= '0;
            e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
            ma_q <= '0; mb_q <= '0; acc_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            x3_q <= '0; y3_q <= '0; z3_q <= '0; t3_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cx1_q <= cx1_d; cy1_q <= cy1_d; cz1_q <= cz1_d; ct1_q <= ct1_d;
            cx2_q <= cx2_d; cy2_q <= cy2_d; cz2_q <= cz2_d; ct2_q <= ct2_d;
            r_q <= r_d;
            p_q <= p_d;
            e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
            ma_q <= ma_d; mb_q <= mb_d; acc_q <= acc_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            x3_q <= x3_d; y3_q <= y3_d; z3_q <= z3_d; t3_q <= t3_d;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done      = (state_q == S_FIN);
    assign x3        = x3_q;
    assign y3        = y3_q;
    assign z3        = z3_q;
    assign t3        = t3_q;
    assign dbg_state = state_q;

endmodule
